// File: rtl/intc_pkg.sv
// ============================================================================
//  Module   : intc_pkg
//  Brief    : Shared cause codes, controller state type and cause mapping.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package intc_pkg;

    localparam logic [31:0] CAUSE_NONE     = 32'd0;
    localparam logic [31:0] CAUSE_TIMER    = 32'd1;
    localparam logic [31:0] CAUSE_HALT     = 32'd2;
    localparam logic [31:0] CAUSE_EXT_BASE = 32'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        HANDLER = 2'd2
    } state_t;

    // Pending vector layout: bit 0 halt, bit 1 timer, bits 2.. external lines.
    function automatic logic [31:0] cause_of_bit(input int idx);
        if (idx == 0) begin
            return CAUSE_HALT;
        end else if (idx == 1) begin
            return CAUSE_TIMER;
        end else begin
            return CAUSE_EXT_BASE + 32'(idx - 2);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/intc_prio_enc.sv
// ============================================================================
//  Module   : intc_prio_enc
//  Brief    : Fixed-priority encoder, lowest pending index wins.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] pend,
    output logic             valid,
    output logic [31:0]      cause
);

    always_comb begin
        valid = 1'b0;
        cause = CAUSE_NONE;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                valid = 1'b1;
                cause = cause_of_bit(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/intc_multi.sv
// ============================================================================
//  Module   : intc_multi
//  Brief    : Interrupt controller: halt, quantum timer and N maskable lines.
//             Timer present only when INTC_TIMER_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module intc_multi
    import intc_pkg::*;
#(
    parameter int                N_SRC  = 4,
    parameter int                PC_W   = 11,
    parameter int                TIME_W = 16,
    parameter logic [PC_W-1:0]   VECTOR = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 halt_i,
    input  logic [N_SRC-1:0]     ext_irq_i,
    input  logic [N_SRC-1:0]     irq_mask_i,
    input  logic                 set_time_i,
    input  logic [TIME_W-1:0]    time_i,
    input  logic [PC_W-1:0]      pc_i,
    input  logic                 ack_i,
    input  logic                 ret_i,
    output logic                 redirect_o,
    output logic [PC_W-1:0]      vector_o,
    output logic [PC_W-1:0]      saved_pc_o,
    output logic [31:0]          cause_o,
    output logic                 busy_o
);

    localparam int c_pend_w = N_SRC + 2;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_pend_w-1:0]   r_pend;
    logic [c_pend_w-1:0]   w_set;
    logic [c_pend_w-1:0]   w_clr;
    logic [c_pend_w-1:0]   w_elig;
    logic                  w_valid;
    logic [31:0]           w_win_cause;
    logic [31:0]           r_cause;
    logic [PC_W-1:0]       r_saved_pc;
    logic                  w_timer_exp;

`ifdef INTC_TIMER_EN
    logic                  r_run;
    logic [TIME_W-1:0]     r_count;
    logic [TIME_W-1:0]     r_reload;

    // A load in the same cycle as an expiry discards the expiry.
    assign w_timer_exp = r_run && !busy_o && !set_time_i && (r_count == TIME_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run    <= 1'b0;
            r_count  <= '0;
            r_reload <= '0;
        end else if (set_time_i) begin
            if (time_i != '0) begin
                r_run    <= 1'b1;
                r_count  <= time_i;
                r_reload <= time_i;
            end else begin
                r_run    <= 1'b0;
            end
        end else if (r_run && !busy_o) begin
            r_count <= (r_count > TIME_W'(1)) ? r_count - TIME_W'(1) : r_reload;
        end
    end
`else
    logic w_unused_timer;

    assign w_unused_timer = ^{set_time_i, time_i};
    assign w_timer_exp    = 1'b0;
`endif

    assign w_set  = {ext_irq_i, w_timer_exp, halt_i};
    assign w_elig = r_pend & {irq_mask_i, 2'b11};

    always_comb begin
        w_clr = '0;
        if (r_state == HANDLER && ack_i) begin
            for (int k = 0; k < c_pend_w; k++) begin
                if (r_cause == cause_of_bit(k)) begin
                    w_clr[k] = 1'b1;
                end
            end
        end
    end

    intc_prio_enc #(
        .WIDTH (c_pend_w)
    ) u_prio_enc (
        .pend  (w_elig),
        .valid (w_valid),
        .cause (w_win_cause)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_state_nxt = TAKE;
            TAKE:    w_state_nxt = HANDLER;
            HANDLER: if (ret_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Setting wins over clearing so an event coinciding with its ack is kept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend     <= '0;
            r_cause    <= CAUSE_NONE;
            r_saved_pc <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
            if (r_state == IDLE && w_valid) begin
                r_cause <= w_win_cause;
            end else if (r_state == HANDLER && ack_i) begin
                r_cause <= CAUSE_NONE;
            end
            if (r_state == TAKE) begin
                r_saved_pc <= pc_i;
            end
        end
    end

    assign redirect_o = (r_state == TAKE);
    assign busy_o     = (r_state == HANDLER);
    assign vector_o   = VECTOR;
    assign saved_pc_o = r_saved_pc;
    assign cause_o    = r_cause;

endmodule

`default_nettype wire

// File: tb/tb_intc_multi.sv
// ============================================================================
//  Module   : tb_intc_multi
//  Brief    : Directed self-checking bench for intc_multi.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_intc_multi;

    localparam int              N_SRC  = 4;
    localparam int              PC_W   = 11;
    localparam int              TIME_W = 16;
    localparam logic [PC_W-1:0] VEC    = 11'h100;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              halt_i;
    logic [N_SRC-1:0]  ext_irq_i;
    logic [N_SRC-1:0]  irq_mask_i;
    logic              set_time_i;
    logic [TIME_W-1:0] time_i;
    logic [PC_W-1:0]   pc_i;
    logic              ack_i;
    logic              ret_i;
    logic              redirect_o;
    logic [PC_W-1:0]   vector_o;
    logic [PC_W-1:0]   saved_pc_o;
    logic [31:0]       cause_o;
    logic              busy_o;

    int n_checks = 0;
    int n_errors = 0;
    int seen;

    intc_multi #(
        .N_SRC  (N_SRC),
        .PC_W   (PC_W),
        .TIME_W (TIME_W),
        .VECTOR (VEC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .halt_i     (halt_i),
        .ext_irq_i  (ext_irq_i),
        .irq_mask_i (irq_mask_i),
        .set_time_i (set_time_i),
        .time_i     (time_i),
        .pc_i       (pc_i),
        .ack_i      (ack_i),
        .ret_i      (ret_i),
        .redirect_o (redirect_o),
        .vector_o   (vector_o),
        .saved_pc_o (saved_pc_o),
        .cause_o    (cause_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; halt_i = 1'b0; ext_irq_i = '0; irq_mask_i = '0;
        set_time_i = 1'b0; time_i = '0; pc_i = 11'h0AA; ack_i = 1'b0; ret_i = 1'b0;
        tick(2);
        check("rst_redirect", redirect_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_cause", cause_o, 0);
        check("rst_saved_pc", saved_pc_o, 0);
        check("vector", vector_o, VEC);
        rst_n = 1'b1;
        tick();

`ifdef INTC_TIMER_EN
        // Quantum 5 loaded at edge 0: pending at edge 5, TAKE after edge 6.
        set_time_i = 1'b1; time_i = 16'd5;
        tick();
        set_time_i = 1'b0;
        tick(4);
        check("tmr_early", redirect_o, 0);
        tick();
        check("tmr_pend_edge", redirect_o, 0);
        tick();
        check("tmr_take", redirect_o, 1);
        check("tmr_cause", cause_o, 1);
        set_time_i = 1'b1; time_i = '0; pc_i = 11'h055;
        tick();
        set_time_i = 1'b0;
        check("tmr_redirect_once", redirect_o, 0);
        check("tmr_busy", busy_o, 1);
        check("tmr_saved_pc", saved_pc_o, 11'h055);
        ack_i = 1'b1; tick(); ack_i = 1'b0;
        ret_i = 1'b1; tick(); ret_i = 1'b0;
        tick(2);
        check("tmr_done", redirect_o, 0);
`endif

        // Masked line stays silent, unmasking takes it next cycle.
        ext_irq_i = 4'b0100;
        tick();
        ext_irq_i = '0;
        tick(3);
        check("masked_redirect", redirect_o, 0);
        check("masked_busy", busy_o, 0);
        irq_mask_i = 4'b0100;
        tick();
        check("unmask_take", redirect_o, 1);
        check("unmask_cause", cause_o, 5);
        pc_i = 11'h123;
        tick();
        check("unmask_busy", busy_o, 1);
        check("unmask_saved_pc", saved_pc_o, 11'h123);
        ack_i = 1'b1; tick(); ack_i = 1'b0;
        check("ack_cause_zero", cause_o, 0);
        check("ack_still_busy", busy_o, 1);
        ret_i = 1'b1; tick(); ret_i = 1'b0;
        check("ret_idle", busy_o, 0);
        tick();
        check("cleared_no_retake", redirect_o, 0);

        // Halt and ext[0] together: halt first, ext[0] after one idle cycle.
        irq_mask_i = 4'b1111;
        halt_i = 1'b1; ext_irq_i = 4'b0001;
        tick();
        halt_i = 1'b0; ext_irq_i = '0;
        check("halt_latency", redirect_o, 0);
        tick();
        check("halt_take", redirect_o, 1);
        check("halt_cause", cause_o, 2);
        tick();
        ack_i = 1'b1; tick(); ack_i = 1'b0;
        ret_i = 1'b1; tick(); ret_i = 1'b0;
        check("halt_ret_idle", redirect_o, 0);
        tick();
        check("ext0_take", redirect_o, 1);
        check("ext0_cause", cause_o, 3);
        tick();
        ack_i = 1'b1; ret_i = 1'b1; tick(); ack_i = 1'b0; ret_i = 1'b0;
        tick();
        check("ack_ret_same", redirect_o, 0);

        // No nesting: ext[1] arriving in HANDLER waits for the ret.
        ext_irq_i = 4'b1000;
        tick();
        ext_irq_i = '0;
        tick();
        check("ext3_cause", cause_o, 6);
        tick();
        ext_irq_i = 4'b0010;
        tick();
        ext_irq_i = '0;
        tick();
        check("nest_redirect", redirect_o, 0);
        check("nest_busy", busy_o, 1);
        check("nest_cause", cause_o, 6);
        ack_i = 1'b1; tick(); ack_i = 1'b0;
        ret_i = 1'b1; tick(); ret_i = 1'b0;
        tick();
        check("ext1_take", redirect_o, 1);
        check("ext1_cause", cause_o, 4);
        tick();

        // ret without ack retakes the same cause.
        ret_i = 1'b1; tick(); ret_i = 1'b0;
        check("noack_idle", busy_o, 0);
        tick();
        check("noack_retake", redirect_o, 1);
        check("noack_cause", cause_o, 4);
        tick();
        ack_i = 1'b1; ret_i = 1'b1; tick(); ack_i = 1'b0; ret_i = 1'b0;

        // Reset mid-HANDLER with the timer loaded.
        set_time_i = 1'b1; time_i = 16'd30;
        tick();
        set_time_i = 1'b0;
        ext_irq_i = 4'b0001; pc_i = 11'h3C7;
        tick();
        ext_irq_i = '0;
        tick(2);
        check("pre_rst_busy", busy_o, 1);
        check("pre_rst_saved", saved_pc_o, 11'h3C7);
        rst_n = 1'b0;
        tick();
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_redirect", redirect_o, 0);
        check("mid_rst_cause", cause_o, 0);
        check("mid_rst_saved", saved_pc_o, 0);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            tick();
            if (redirect_o || busy_o) seen++;
        end
        check("post_rst_quiet", seen, 0);

`ifndef INTC_TIMER_EN
        set_time_i = 1'b1; time_i = 16'd3;
        tick();
        set_time_i = 1'b0;
        seen = 0;
        repeat (10) begin
            tick();
            if (redirect_o) seen++;
        end
        check("no_timer", seen, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
